// File: rtl/dac_spi_pkg.sv
// Shared frame layout, command codes and FSM encoding for the DAC SPI responder.
package dac_spi_pkg;

  localparam int FRAME_BITS_DEF = 24;
  localparam int CMD_W          = 4;
  localparam int ADDR_W         = 4;
  localparam int DATA_W         = 16;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP    = 4'h0,
    CMD_WR_IN  = 4'h1,
    CMD_UPDATE = 4'h2,
    CMD_WR_UPD = 4'h3
  } cmd_e;

  // Field order matches the wire order: cmd arrives first (MSB first).
  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHIFT     = 2'd1,
    ST_WAIT_HIGH = 2'd2
  } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall pulses
// derived from the synchronized level.
module spi_pin_sync #(
  parameter int   STAGES     = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_l,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              q_d;

  // NOTE: non-blocking assignments make every stage sample the previous
  // stage's old value, so the chain really is STAGES flops deep.
  always_ff @(posedge clk) begin
    if (rst_l) begin
      chain <= {STAGES{IDLE_LEVEL}};
      q_d   <= IDLE_LEVEL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/dac_spi_responder.sv
// SPI responder emulating a serial 16-bit DAC: frame decode, input/DAC
// registers, LDAc/CLRn handling and echo of the previous frame on SDO.
module dac_spi_responder
  import dac_spi_pkg::*;
#(
  parameter int          FRAME_BITS  = FRAME_BITS_DEF,
  parameter logic [15:0] CLEAR_CODE  = 16'h0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        CSn,
  input  logic        SCK,
  input  logic        SDI,
  output logic        SDO,
  input  logic        LDAc,
  input  logic        CLRn,
  output logic [15:0] dac_code,
  output logic [15:0] input_reg,
  output logic        dac_update,
  output logic        frame_err
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam int SET_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam logic [SET_W-1:0] SETTLE_N = SET_W'(SYNC_STAGES);

  logic cs_q, cs_rise, cs_fall;
  logic sck_q, sck_rise, sck_fall;
  logic sdi_q, sdi_rise, sdi_fall;
  logic ldac_q, ldac_rise, ldac_fall;
  logic clr_q, clr_rise, clr_fall;
  logic unused_sync;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_cs (
    .clk(clk), .rst_l(rst_l), .d(CSn), .q(cs_q), .rise(cs_rise), .fall(cs_fall));
  spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sck (
    .clk(clk), .rst_l(rst_l), .d(SCK), .q(sck_q), .rise(sck_rise), .fall(sck_fall));
  spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sdi (
    .clk(clk), .rst_l(rst_l), .d(SDI), .q(sdi_q), .rise(sdi_rise), .fall(sdi_fall));
  spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_ldac (
    .clk(clk), .rst_l(rst_l), .d(LDAc), .q(ldac_q), .rise(ldac_rise), .fall(ldac_fall));
  spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_clr (
    .clk(clk), .rst_l(rst_l), .d(CLRn), .q(clr_q), .rise(clr_rise), .fall(clr_fall));

  assign unused_sync = &{sck_q, sdi_rise, sdi_fall, ldac_q, ldac_rise, clr_rise};

  state_e                state;
  logic [SET_W-1:0]      settle_cnt;
  logic                  settled;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] rx_sr;
  logic [FRAME_BITS-1:0] echo_sr;
  logic [FRAME_BITS-1:0] echo_src;
  frame_t                frame;
  logic                  commit;
  logic [15:0]           commit_in;
  logic [15:0]           commit_dac;
  logic                  commit_upd;

  // Synchronizers come out of reset at idle levels, not pin levels; the FSM
  // waits until they have flushed before trusting CSn high.
  assign settled = (settle_cnt == SETTLE_N);
  assign frame   = rx_sr[FRAME_BITS-1 -: $bits(frame_t)];
  assign commit  = (state == ST_SHIFT) && cs_rise && (bit_cnt == CNT_FULL);

  // NOTE: every output gets a default first, so no path leaves a latch.
  always_comb begin
    commit_in  = input_reg;
    commit_dac = dac_code;
    commit_upd = 1'b0;
    if (commit && frame.addr == '0) begin
      case (frame.cmd)
        CMD_WR_IN:  commit_in = frame.data;
        CMD_UPDATE: begin
          commit_dac = input_reg;
          commit_upd = 1'b1;
        end
        CMD_WR_UPD: begin
          commit_in  = frame.data;
          commit_dac = frame.data;
          commit_upd = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_l) begin
      state      <= ST_WAIT_HIGH;
      settle_cnt <= '0;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      echo_sr    <= '0;
      echo_src   <= '0;
      SDO        <= 1'b0;
      input_reg  <= CLEAR_CODE;
      dac_code   <= CLEAR_CODE;
      dac_update <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (!settled) settle_cnt <= settle_cnt + 1'b1;

      case (state)
        ST_WAIT_HIGH: begin
          SDO <= 1'b0;
          if (settled && cs_q) state <= ST_IDLE;
        end
        ST_IDLE: begin
          SDO <= 1'b0;
          if (cs_fall) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            echo_sr <= echo_src;
            SDO     <= echo_src[FRAME_BITS-1];
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state <= ST_IDLE;
            SDO   <= 1'b0;
            if (bit_cnt == CNT_FULL) echo_src  <= rx_sr;
            else                     frame_err <= 1'b1;
          end else begin
            if (sck_rise) begin
              rx_sr <= {rx_sr[FRAME_BITS-2:0], sdi_q};
              if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
            end
            if (sck_fall) begin
              echo_sr <= {echo_sr[FRAME_BITS-2:0], 1'b0};
              SDO     <= echo_sr[FRAME_BITS-2];
            end
          end
        end
        default: state <= ST_WAIT_HIGH;
      endcase

      // CLRn overrides everything; LDAc sees the input_reg a same-cycle commit wrote.
      if (!clr_q) begin
        input_reg  <= CLEAR_CODE;
        dac_code   <= CLEAR_CODE;
        dac_update <= clr_fall;
      end else begin
        input_reg  <= commit_in;
        dac_code   <= ldac_fall ? commit_in : commit_dac;
        dac_update <= commit_upd | ldac_fall;
      end
    end
  end

endmodule

// File: tb/tb_dac_spi_responder.sv
// Self-checking bench for dac_spi_responder: directed table, multi-cycle
// corner sequences and randomized frames against a frame-level model.
module tb_dac_spi_responder;

  logic        clk = 1'b0;
  logic        rst_l = 1'b1;
  logic        CSn = 1'b1, SCK = 1'b0, SDI = 1'b0, LDAc = 1'b1, CLRn = 1'b1;
  logic        SDO;
  logic [15:0] dac_code, input_reg;
  logic        dac_update, frame_err;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int err_cnt = 0;
  int exp_upd = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  dac_spi_responder dut (
    .clk(clk), .rst_l(rst_l), .CSn(CSn), .SCK(SCK), .SDI(SDI), .SDO(SDO),
    .LDAc(LDAc), .CLRn(CLRn), .dac_code(dac_code), .input_reg(input_reg),
    .dac_update(dac_update), .frame_err(frame_err));

  always @(negedge clk) begin
    if (dac_update === 1'b1) upd_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    logic [23:0] exp_echo;
    logic [15:0] exp_in;
    logic [15:0] exp_dac;
    int          d_err;
    int          d_upd;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] echo_mask(input int n);
    if (n >= 24) return 24'hFFFFFF;
    return ~((24'h1 << (24 - n)) - 24'h1);
  endfunction

  // Clocks n bits MSB first in mode 0, capturing SDO before each rising edge.
  task automatic clock_bits(input logic [31:0] bits, input int n, output logic [23:0] echo);
    echo = '0;
    for (int i = 0; i < n; i++) begin
      SDI = bits[n-1-i];
      cyc(4);
      if (i < 24) echo[23-i] = SDO;
      SCK = 1'b1;
      cyc(4);
      SCK = 1'b0;
    end
  endtask

  task automatic shift_frame(input logic [31:0] bits, input int n, output logic [23:0] echo);
    CSn = 1'b0;
    cyc(4);
    clock_bits(bits, n, echo);
    cyc(4);
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n, output logic [23:0] echo);
    shift_frame(bits, n, echo);
    CSn = 1'b1;
    cyc(8);
  endtask

  task automatic ldac_pulse();
    LDAc = 1'b0;
    cyc(6);
    LDAc = 1'b1;
    cyc(6);
  endtask

  initial begin
    logic [23:0] got, f, exp_echo_w;
    logic [31:0] bits;
    logic [15:0] m_in, m_dac;
    logic [23:0] m_echo;
    logic [4:0]  upd_seen;
    logic [15:0] dac_seen [5];
    logic        ld;
    int          n, r;

    vecs[0] = '{32'h0020_0000, 24, 24'h101234, 16'h1234, 16'h1234, 0, 1};
    vecs[1] = '{32'h007F_FFFF, 23, 24'h200000, 16'h1234, 16'h1234, 1, 0};
    vecs[2] = '{32'h01F0_FFFF, 25, 24'h200000, 16'h1234, 16'h1234, 1, 0};
    vecs[3] = '{32'h0030_5555, 24, 24'h200000, 16'h5555, 16'h5555, 0, 1};
    vecs[4] = '{32'h0000_0000, 24, 24'h305555, 16'h5555, 16'h5555, 0, 0};
    vecs[5] = '{32'h0011_2222, 24, 24'h000000, 16'h5555, 16'h5555, 0, 0};
    vecs[6] = '{32'h0070_BEEF, 24, 24'h112222, 16'h5555, 16'h5555, 0, 0};
    vecs[7] = '{32'h0010_BEEF, 24, 24'h70BEEF, 16'hBEEF, 16'h5555, 0, 0};
    vecs[8] = '{32'h0020_0000, 24, 24'h10BEEF, 16'hBEEF, 16'hBEEF, 0, 1};

    // Reset state
    cyc(5);
    check("reset_dac_code", dac_code, 16'h0000);
    check("reset_input_reg", input_reg, 16'h0000);
    check("reset_sdo", SDO, 1'b0);
    check("reset_dac_update", dac_update, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    rst_l = 1'b0;
    cyc(8);

    // Write+update frame with commit latency measured from the CSn rise
    shift_frame(32'h0030_ABCD, 24, got);
    check("abcd_echo", got, 24'h000000);
    CSn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      upd_seen[k] = dac_update;
      dac_seen[k] = dac_code;
    end
    check("abcd_upd_latency", upd_seen, 5'b01000);
    check("abcd_dac_before", dac_seen[2], 16'h0000);
    check("abcd_dac_after", dac_seen[3], 16'hABCD);
    cyc(4);
    check("abcd_input_reg", input_reg, 16'hABCD);
    exp_upd++;

    // Write input only, then LDAc falling edge transfers it
    send_frame(32'h0010_1234, 24, got);
    check("wr_in_echo", got, 24'h30ABCD);
    check("wr_in_input_reg", input_reg, 16'h1234);
    check("wr_in_dac_held", dac_code, 16'hABCD);
    check("wr_in_no_update", upd_cnt, exp_upd);
    LDAc = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      upd_seen[k] = dac_update;
      dac_seen[k] = dac_code;
    end
    check("ldac_upd_latency", upd_seen, 5'b01000);
    check("ldac_dac_before", dac_seen[2], 16'hABCD);
    check("ldac_dac_after", dac_seen[3], 16'h1234);
    cyc(4);
    LDAc = 1'b1;
    cyc(6);
    exp_upd++;
    check("ldac_rise_no_update", upd_cnt, exp_upd);

    // Directed frame table
    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].bits, vecs[i].nbits, got);
      exp_err += vecs[i].d_err;
      exp_upd += vecs[i].d_upd;
      check($sformatf("vec%0d_echo", i), got & echo_mask(vecs[i].nbits),
            vecs[i].exp_echo & echo_mask(vecs[i].nbits));
      check($sformatf("vec%0d_input_reg", i), input_reg, vecs[i].exp_in);
      check($sformatf("vec%0d_dac_code", i), dac_code, vecs[i].exp_dac);
      check($sformatf("vec%0d_err_cnt", i), err_cnt, exp_err);
      check($sformatf("vec%0d_upd_cnt", i), upd_cnt, exp_upd);
    end

    // Commit and LDAc edge together: LDAc moves the freshly written input_reg
    shift_frame(32'h0010_4321, 24, got);
    CSn = 1'b1;
    LDAc = 1'b0;
    cyc(8);
    exp_upd++;
    check("coinc_input_reg", input_reg, 16'h4321);
    check("coinc_dac_code", dac_code, 16'h4321);
    check("coinc_single_update", upd_cnt, exp_upd);
    LDAc = 1'b1;
    cyc(6);

    // CLRn low across a write+update commit and an LDAc edge
    CLRn = 1'b0;
    cyc(6);
    exp_upd++;
    check("clr_dac_code", dac_code, 16'h0000);
    check("clr_input_reg", input_reg, 16'h0000);
    shift_frame(32'h0030_FFFF, 24, got);
    CSn = 1'b1;
    LDAc = 1'b0;
    cyc(8);
    check("clr_hold_dac_code", dac_code, 16'h0000);
    check("clr_hold_input_reg", input_reg, 16'h0000);
    check("clr_single_update", upd_cnt, exp_upd);
    check("clr_no_err", err_cnt, exp_err);
    LDAc = 1'b1;
    CLRn = 1'b1;
    cyc(6);
    check("clr_release_dac_code", dac_code, 16'h0000);
    check("clr_release_update", upd_cnt, exp_upd);

    // Reset mid-frame with CSn held low across the release
    CSn = 1'b0;
    cyc(4);
    clock_bits(32'h0030_AAAA >> 14, 10, got);
    rst_l = 1'b1;
    cyc(4);
    rst_l = 1'b0;
    cyc(2);
    clock_bits(32'h0030_AAAA & 32'h3FFF, 14, got);
    check("midrst_sdo_quiet", got, 24'h000000);
    cyc(4);
    CSn = 1'b1;
    cyc(8);
    check("midrst_input_reg", input_reg, 16'h0000);
    check("midrst_dac_code", dac_code, 16'h0000);
    check("midrst_no_err", err_cnt, exp_err);
    check("midrst_no_update", upd_cnt, exp_upd);
    send_frame(32'h0030_0F0F, 24, got);
    exp_upd++;
    check("post_rst_echo", got, 24'h000000);
    check("post_rst_dac_code", dac_code, 16'h0F0F);
    check("post_rst_input_reg", input_reg, 16'h0F0F);
    check("post_rst_update", upd_cnt, exp_upd);

    // Randomized frames against a frame-level model
    m_in = 16'h0F0F;
    m_dac = 16'h0F0F;
    m_echo = 24'h300F0F;
    for (int t = 0; t < 24; t++) begin
      f = 24'($urandom);
      f[23:20] = 4'($urandom_range(0, 4));
      f[19:16] = ($urandom_range(0, 7) == 0) ? 4'h1 : 4'h0;
      r = $urandom_range(0, 9);
      n = (r == 0) ? 23 : ((r == 1) ? 25 : 24);
      if (n == 25)      bits = {7'b0, 1'b1, f};
      else if (n == 23) bits = {9'b0, f[23:1]};
      else              bits = {8'b0, f};
      ld = ($urandom_range(0, 3) == 0);

      send_frame(bits, n, got);
      if (ld) ldac_pulse();

      exp_echo_w = m_echo;
      if (n == 24) begin
        m_echo = f;
        if (f[19:16] == 4'h0) begin
          case (f[23:20])
            4'h1: m_in = f[15:0];
            4'h2: begin m_dac = m_in; exp_upd++; end
            4'h3: begin m_in = f[15:0]; m_dac = f[15:0]; exp_upd++; end
            default: ;
          endcase
        end
      end else begin
        exp_err++;
      end
      if (ld) begin
        m_dac = m_in;
        exp_upd++;
      end

      check($sformatf("rnd%0d_echo", t), got & echo_mask(n), exp_echo_w & echo_mask(n));
      check($sformatf("rnd%0d_input_reg", t), input_reg, m_in);
      check($sformatf("rnd%0d_dac_code", t), dac_code, m_dac);
      check($sformatf("rnd%0d_err_cnt", t), err_cnt, exp_err);
      check($sformatf("rnd%0d_upd_cnt", t), upd_cnt, exp_upd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
